p405s_dcdbrpredecq: RTL

Branch pre-decode queue between the instruction fetch buffer and the branch unit. Each accepted instruction is decoded for b, bc/bclr/bcctr, CR0-update and mtspr classes, then tagged and held in a parametrised FIFO. The FIFO also tracks queued branches and flags any bc that follows an in-flight mtspr to LR/CTR. Generalises the single-word combinational branch PLA with depth, tagging, flush and hazard tracking.

---
 rtl/p405s_dcdbrpredecq.sv | 139 +++++++++++++
 1 files changed

// File: rtl/p405s_dcdbrpredecq.sv
// Branch pre-decode queue: classifies b/bc/CR0/mtspr at push, holds tagged entries; optional P405S_DCDBR_HAZARD_EN flags bc behind queued mtspr LR/CTR.
// Latency: 1 cycle push-to-head; occupancy and branch counts are registered.
// Backpressure: dcdReady = not full (state only); a push while full is refused even with a same-cycle pop.
module p405s_dcdbrpredecq #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             CB,
    input  logic             reset,
    input  logic [0:31]      ifbInst,
    input  logic [TAG_W-1:0] ifbTag,
    input  logic             ifbValid,
    output logic             dcdReady,
    input  logic             flush,
    input  logic             exeRdy,
    output logic             dcdValid,
    output logic             dcdB,
    output logic             dcdBc,
    output logic             dcdCr0En,
    output logic             dcdMtspr,
    output logic             dcdMtLrCtr,
    output logic             dcdHazard,
    output logic [TAG_W-1:0] dcdTag,
    output logic [CNT_W-1:0] dcdCount,
    output logic [CNT_W-1:0] dcdBrCnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef struct packed {
        logic             b;
        logic             bc;
        logic             cr0_en;
        logic             mtspr;
        logic             mtlrctr;
        logic [TAG_W-1:0] tag;
    } entry_t;

    logic [PW-1:0] wptr, rptr;
    logic [AW-1:0] wa, ra;
    logic          full, empty, push, pop;
    entry_t        mem [DEPTH];
    entry_t        din, head;

    logic [5:0] pri_op;
    logic [9:0] sec_op;
    logic [9:0] spr;
    logic       rc;
    logic       unused_rs;

    // IBM bit numbering: the port is declared [0:31] so fields slice directly.
    assign pri_op    = ifbInst[0:5];
    assign sec_op    = ifbInst[21:30];
    assign spr       = ifbInst[11:20];
    assign rc        = ifbInst[31];
    assign unused_rs = ^ifbInst[6:10];

    always_comb begin
        din         = '0;
        din.tag     = ifbTag;
        din.b       = (pri_op == 6'd18);
        // Bit 21 of the XO field is ignored so bclr and bcctr both decode as bc.
        din.bc      = (pri_op == 6'd16) ||
                      ((pri_op == 6'd19) && (sec_op[8:0] == 9'b000010000));
        din.cr0_en  = (rc && (pri_op inside {6'd4, 6'd20, 6'd21, 6'd23, 6'd29, 6'd31})) ||
                      (pri_op inside {6'd13, 6'd28, 6'd29});
        din.mtspr   = (pri_op == 6'd31) && (sec_op == 10'b0111010011);
        din.mtlrctr = din.mtspr && ((spr == 10'b0100000000) || (spr == 10'b0100100000));
    end

    assign wa    = wptr[AW-1:0];
    assign ra    = rptr[AW-1:0];
    assign full  = (wptr[AW] != rptr[AW]) && (wa == ra);
    assign empty = (wptr == rptr);
    assign push  = ifbValid & ~full & ~flush;
    assign pop   = exeRdy & ~empty & ~flush;
    assign head  = mem[ra];

    always_ff @(posedge CB or posedge reset) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            dcdCount <= '0;
            dcdBrCnt <= '0;
        end else if (flush) begin
            wptr     <= '0;
            rptr     <= '0;
            dcdCount <= '0;
            dcdBrCnt <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            dcdCount <= dcdCount + CNT_W'(push) - CNT_W'(pop);
            dcdBrCnt <= dcdBrCnt + CNT_W'(push & (din.b | din.bc))
                                 - CNT_W'(pop & (head.b | head.bc));
        end
    end

    // Payload storage needs no reset; the head is masked while empty.
    always_ff @(posedge CB) begin
        if (push) mem[wa] <= din;
    end

`ifdef P405S_DCDBR_HAZARD_EN
    logic [CNT_W-1:0] lrctr_cnt;
    logic             hz_mem [DEPTH];

    always_ff @(posedge CB or posedge reset) begin
        if (reset) begin
            lrctr_cnt <= '0;
        end else if (flush) begin
            lrctr_cnt <= '0;
        end else begin
            lrctr_cnt <= lrctr_cnt + CNT_W'(push & din.mtlrctr) - CNT_W'(pop & head.mtlrctr);
        end
    end

    // Pre-edge count: an mtspr leaving in this same cycle still counts as in flight.
    always_ff @(posedge CB) begin
        if (push) hz_mem[wa] <= din.bc & (lrctr_cnt != '0);
    end

    assign dcdHazard = ~empty & hz_mem[ra];
`else
    assign dcdHazard = 1'b0;
`endif

    assign dcdReady   = ~full;
    assign dcdValid   = ~empty;
    assign dcdB       = ~empty & head.b;
    assign dcdBc      = ~empty & head.bc;
    assign dcdCr0En   = ~empty & head.cr0_en;
    assign dcdMtspr   = ~empty & head.mtspr;
    assign dcdMtLrCtr = ~empty & head.mtlrctr;
    assign dcdTag     = {TAG_W{~empty}} & head.tag;

endmodule
